// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - host command and read-return bus of the screen RAM arbiter
interface vram_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
);
  logic              host_valid;
  logic              host_ready;
  logic              host_write;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  modport master (
    output host_valid, host_write, host_addr, host_wdata,
    input  host_ready, host_rvalid, host_rdata
  );

  modport slave (
    input  host_valid, host_write, host_addr, host_wdata,
    output host_ready, host_rvalid, host_rdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - screen RAM arbiter: video reads first, queued host commands fill idle cycles
// Optional host readback path enabled by defining VRAM_READBACK_EN.
module vram_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          vid_req,
  input  logic [ADDR_W-1:0]             vid_addr,
  output logic [DATA_W-1:0]             vid_data,
  vram_arbiter_if.slave                 host,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic                          ram_we,
  output logic [DATA_W-1:0]             ram_wdata,
  input  logic [DATA_W-1:0]             ram_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);

  logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] q_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              ready;
  logic              push;
  logic              pop;
  logic              head_write;

  // Ready looks only at the registered level, so a same-cycle pop never frees a slot early.
  assign ready           = (level != FULL_LEVEL);
  assign push            = host.host_valid & ready;
  assign pop             = ~vid_req & (level != '0);
  assign host.host_ready = ready;
  assign fifo_level      = level;
  assign vid_data        = ram_rdata;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      q_addr[wr_ptr] <= host.host_addr;
      q_data[wr_ptr] <= host.host_wdata;
    end
  end

`ifdef VRAM_READBACK_EN
  logic              q_write [FIFO_DEPTH];
  logic              rd_pend;
  logic [DATA_W-1:0] rdata_q;

  assign head_write = q_write[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) q_write[wr_ptr] <= host.host_write;
  end

  // RAM data for a popped read arrives one cycle later; forward it then and keep a copy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_pend <= 1'b0;
      rdata_q <= '0;
    end else begin
      rd_pend <= pop & ~head_write;
      if (rd_pend) rdata_q <= ram_rdata;
    end
  end

  assign host.host_rvalid = rd_pend;
  assign host.host_rdata  = rd_pend ? ram_rdata : rdata_q;
`else
  logic unused_host_write;

  assign unused_host_write = host.host_write;
  assign head_write        = 1'b1;
  assign host.host_rvalid  = 1'b0;
  assign host.host_rdata   = '0;
`endif

  always_comb begin
    ram_addr  = vid_addr;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (pop) begin
      ram_addr  = q_addr[rd_ptr];
      ram_we    = head_write;
      ram_wdata = q_data[rd_ptr];
    end
  end
endmodule
